// File: rtl/debug_sequencer.sv
// Debug-ring command sequencer: halts the core, waits for the pipeline to drain,
// then performs register and PC accesses while halted. Define DEBUG_SEQ_STEP_EN to add single-step.
module debug_sequencer #(
  parameter int XLEN          = 64,
  parameter int ADDR_W        = 40,
  parameter int DRAIN_TIMEOUT = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [4:0]        cmd_addr_i,
  input  logic [XLEN-1:0]   cmd_data_i,
  input  logic              pipe_busy_i,
  input  logic [XLEN-1:0]   reg_read_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o,
  output logic              halted_o,
  output logic              halt_valid_o,
  output logic              change_pc_valid_o,
  output logic [ADDR_W-1:0] change_pc_addr_o,
  output logic              reg_read_valid_o,
  output logic              reg_write_valid_o,
  output logic [4:0]        reg_read_write_addr_o,
  output logic [XLEN-1:0]   reg_write_data_o
);

  localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RESUME = 3'd2;
  localparam logic [2:0] OP_RD_REG = 3'd3;
  localparam logic [2:0] OP_WR_REG = 3'd4;
  localparam logic [2:0] OP_SET_PC = 3'd5;
`ifdef DEBUG_SEQ_STEP_EN
  localparam logic [2:0] OP_STEP   = 3'd6;
`endif

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_RD,
    S_RD_CAP,
    S_WR,
    S_PC
`ifdef DEBUG_SEQ_STEP_EN
    , S_STEP_RUN
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [XLEN-1:0]    rsp_data_q;
  logic [4:0]         rw_addr_q, rw_addr_d;
  logic [XLEN-1:0]    wr_data_q, wr_data_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  pc_addr_q, pc_addr_d;

  logic               rsp_set;
  logic               rsp_err_d;
  logic [XLEN-1:0]    rsp_data_d;
  logic               cmd_fire;

  assign cmd_ready_o = ((state_q == S_RUN) || (state_q == S_HALTED)) && !rsp_valid_q;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    rw_addr_d   = rw_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = wr_en_q;
    pc_addr_d   = pc_addr_q;
    rsp_set     = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;

    unique case (state_q)
      S_RUN: begin
        if (cmd_fire) begin
          if (cmd_op_i == OP_HALT) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end else begin
            rsp_set   = 1'b1;
            rsp_err_d = 1'b1;
          end
        end
      end

      // A clean drain wins over a timeout that lands in the same cycle.
      S_DRAIN: begin
        if (!pipe_busy_i) begin
          state_d = S_HALTED;
          rsp_set = 1'b1;
        end else if (drain_cnt_q == CNT_LAST) begin
          state_d   = S_HALTED;
          rsp_set   = 1'b1;
          rsp_err_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      S_HALTED: begin
        if (cmd_fire) begin
          case (cmd_op_i)
            OP_HALT: rsp_set = 1'b1;
            OP_RESUME: begin
              state_d = S_RUN;
              rsp_set = 1'b1;
            end
            OP_RD_REG: begin
              state_d   = S_RD;
              rw_addr_d = cmd_addr_i;
            end
            OP_WR_REG: begin
              state_d = S_WR;
              wr_en_d = (cmd_addr_i != 5'd0);
              // x0 writes are dropped, so the strobe fields keep their previous values.
              if (cmd_addr_i != 5'd0) begin
                rw_addr_d = cmd_addr_i;
                wr_data_d = cmd_data_i;
              end
            end
            OP_SET_PC: begin
              state_d   = S_PC;
              pc_addr_d = cmd_data_i[ADDR_W-1:0];
            end
`ifdef DEBUG_SEQ_STEP_EN
            OP_STEP: state_d = S_STEP_RUN;
`endif
            default: begin
              rsp_set   = 1'b1;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end

      S_RD: state_d = S_RD_CAP;

      S_RD_CAP: begin
        state_d    = S_HALTED;
        rsp_set    = 1'b1;
        rsp_data_d = reg_read_data_i;
      end

      S_WR, S_PC: begin
        state_d = S_HALTED;
        rsp_set = 1'b1;
      end

`ifdef DEBUG_SEQ_STEP_EN
      S_STEP_RUN: begin
        state_d     = S_DRAIN;
        drain_cnt_d = '0;
      end
`endif

      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_RUN;
      drain_cnt_q <= '0;
      rw_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      pc_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      rw_addr_q   <= rw_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      pc_addr_q   <= pc_addr_d;
      // Only one command is ever outstanding, so a new response never meets a pending one.
      if (rsp_set) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= rsp_err_d;
        rsp_data_q  <= rsp_data_d;
      end else if (rsp_valid_q && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_data_q  <= '0;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;

`ifdef DEBUG_SEQ_STEP_EN
  assign halt_valid_o = (state_q != S_RUN) && (state_q != S_STEP_RUN);
`else
  assign halt_valid_o = (state_q != S_RUN);
`endif

  assign halted_o = (state_q == S_HALTED) || (state_q == S_RD) || (state_q == S_RD_CAP) ||
                    (state_q == S_WR) || (state_q == S_PC);

  assign reg_read_valid_o      = (state_q == S_RD);
  assign reg_write_valid_o     = (state_q == S_WR) && wr_en_q;
  assign change_pc_valid_o     = (state_q == S_PC);
  assign reg_read_write_addr_o = rw_addr_q;
  assign reg_write_data_o      = wr_data_q;
  assign change_pc_addr_o      = pc_addr_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Randomised bench for debug_sequencer against a transaction-level model of halt/drain/access rules.
`timescale 1ns/1ps
module tb_debug_sequencer;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 40;
  localparam int DT     = 32;

  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RESUME = 3'd2;
  localparam logic [2:0] OP_RD_REG = 3'd3;
  localparam logic [2:0] OP_WR_REG = 3'd4;
  localparam logic [2:0] OP_SET_PC = 3'd5;
  localparam logic [2:0] OP_STEP   = 3'd6;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [2:0]        cmd_op_i;
  logic [4:0]        cmd_addr_i;
  logic [XLEN-1:0]   cmd_data_i;
  logic              pipe_busy_i;
  logic [XLEN-1:0]   reg_read_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [XLEN-1:0]   rsp_data_o;
  logic              rsp_err_o;
  logic              halted_o;
  logic              halt_valid_o;
  logic              change_pc_valid_o;
  logic [ADDR_W-1:0] change_pc_addr_o;
  logic              reg_read_valid_o;
  logic              reg_write_valid_o;
  logic [4:0]        reg_read_write_addr_o;
  logic [XLEN-1:0]   reg_write_data_o;

  int n_checks = 0;
  int n_errors = 0;
  bit model_halted = 0;

  debug_sequencer #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DRAIN_TIMEOUT(DT)) dut (
    .clk_i                 (clk_i),
    .rstn_i                (rstn_i),
    .cmd_valid_i           (cmd_valid_i),
    .cmd_ready_o           (cmd_ready_o),
    .cmd_op_i              (cmd_op_i),
    .cmd_addr_i            (cmd_addr_i),
    .cmd_data_i            (cmd_data_i),
    .pipe_busy_i           (pipe_busy_i),
    .reg_read_data_i       (reg_read_data_i),
    .rsp_valid_o           (rsp_valid_o),
    .rsp_ready_i           (rsp_ready_i),
    .rsp_data_o            (rsp_data_o),
    .rsp_err_o             (rsp_err_o),
    .halted_o              (halted_o),
    .halt_valid_o          (halt_valid_o),
    .change_pc_valid_o     (change_pc_valid_o),
    .change_pc_addr_o      (change_pc_addr_o),
    .reg_read_valid_o      (reg_read_valid_o),
    .reg_write_valid_o     (reg_write_valid_o),
    .reg_read_write_addr_o (reg_read_write_addr_o),
    .reg_write_data_o      (reg_write_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command end to end. Latency counts clock edges from the accepting edge to the edge
  // that registers the response; busy_n is how many post-accept edges see pipe_busy_i=1.
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] addr, input logic [63:0] data,
                        input logic [63:0] rd_val, input int busy_n, input int hold_n);
    int       exp_lat, exp_rd, exp_wr, exp_pc, exp_hv_low;
    bit       exp_err, next_halted, seen;
    logic [63:0] exp_data;
    int       k, n_rd, n_wr, n_pc, n_hv_low;

    exp_err = 1'b1; exp_lat = 0; exp_data = '0;
    exp_rd = 0; exp_wr = 0; exp_pc = 0; exp_hv_low = 0;
    next_halted = model_halted;
    if (!model_halted) begin
      if (op == OP_HALT) begin
        exp_lat     = (busy_n + 1 < DT) ? busy_n + 1 : DT;
        exp_err     = (busy_n >= DT);
        next_halted = 1'b1;
      end
    end else begin
      case (op)
        OP_HALT:   exp_err = 1'b0;
        OP_RESUME: begin exp_err = 1'b0; next_halted = 1'b0; end
        OP_RD_REG: begin exp_err = 1'b0; exp_lat = 2; exp_rd = 1; exp_data = rd_val; end
        OP_WR_REG: begin exp_err = 1'b0; exp_lat = 1; exp_wr = (addr != 5'd0); end
        OP_SET_PC: begin exp_err = 1'b0; exp_lat = 1; exp_pc = 1; end
`ifdef DEBUG_SEQ_STEP_EN
        OP_STEP: begin
          exp_hv_low = 1;
          exp_lat    = (busy_n + 1 < 2) ? 2 : ((busy_n + 1 > DT + 1) ? DT + 1 : busy_n + 1);
          exp_err    = (busy_n >= DT + 1);
        end
`endif
        default: ;
      endcase
    end

    @(negedge clk_i);
    check("cmd_ready_idle", cmd_ready_o, 1'b1);
    cmd_valid_i     = 1'b1;
    cmd_op_i        = op;
    cmd_addr_i      = addr;
    cmd_data_i      = data;
    reg_read_data_i = rd_val;
    pipe_busy_i     = (busy_n > 0);

    seen = 0; k = 0; n_rd = 0; n_wr = 0; n_pc = 0; n_hv_low = 0;
    while (!seen && k < 80) begin
      @(negedge clk_i);
      k++;
      cmd_valid_i = 1'b0;
      cmd_addr_i  = 5'($urandom);
      cmd_data_i  = {$urandom, $urandom};
      pipe_busy_i = (k <= busy_n);
      if (reg_read_valid_o) begin
        n_rd++;
        check("rd_addr", reg_read_write_addr_o, addr);
      end
      if (reg_write_valid_o) begin
        n_wr++;
        check("wr_addr", reg_read_write_addr_o, addr);
        check("wr_data", reg_write_data_o, data);
      end
      if (change_pc_valid_o) begin
        n_pc++;
        check("pc_addr", change_pc_addr_o, data[ADDR_W-1:0]);
      end
      if (!rsp_valid_o && model_halted && !halt_valid_o) n_hv_low++;
      if (rsp_valid_o) seen = 1;
    end
    if (!seen) begin
      check("rsp_timeout", 0, 1);
      return;
    end

    check("latency", k - 1, exp_lat);
    check("rsp_err", rsp_err_o, exp_err);
    check("rsp_data", rsp_data_o, exp_data);
    check("n_rd_strobe", n_rd, exp_rd);
    check("n_wr_strobe", n_wr, exp_wr);
    check("n_pc_strobe", n_pc, exp_pc);
    check("hv_low_cycles", n_hv_low, exp_hv_low);
    check("halted_o", halted_o, next_halted);
    check("halt_valid_o", halt_valid_o, next_halted);
    check("cmd_ready_busy", cmd_ready_o, 1'b0);

    for (int h = 0; h < hold_n; h++) begin
      @(negedge clk_i);
      check("rsp_hold_ctl", {rsp_valid_o, rsp_err_o, cmd_ready_o}, {1'b1, exp_err, 1'b0});
      check("rsp_hold_data", rsp_data_o, exp_data);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("rsp_consumed", {rsp_valid_o, cmd_ready_o}, 2'b01);
    model_halted = next_halted;
  endtask

  initial begin
    logic [2:0]  op;
    int          busy_n;

    rstn_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0; cmd_data_i = '0;
    pipe_busy_i = 1'b0; reg_read_data_i = '0; rsp_ready_i = 1'b0;
    #1;
    check("reset_ctl", {cmd_ready_o, rsp_valid_o, rsp_err_o, halted_o, halt_valid_o,
                        change_pc_valid_o, reg_read_valid_o, reg_write_valid_o}, 8'b1000_0000);
    check("reset_data", rsp_data_o | reg_write_data_o | 64'(change_pc_addr_o) | 64'(reg_read_write_addr_o), 0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;

    do_cmd(OP_HALT,   5'd0, 64'd0, 64'd0, 5, 0);
    do_cmd(OP_RESUME, 5'd0, 64'd0, 64'd0, 0, 0);
    do_cmd(OP_HALT,   5'd0, 64'd0, 64'd0, 40, 0);
    do_cmd(OP_WR_REG, 5'd5, 64'hDEAD_BEEF, 64'd0, 0, 0);
    do_cmd(OP_RD_REG, 5'd5, 64'd0, 64'hDEAD_BEEF, 0, 0);
    do_cmd(OP_WR_REG, 5'd0, 64'h1234, 64'd0, 0, 0);
    do_cmd(OP_SET_PC, 5'd0, 64'h8000_0000, 64'd0, 0, 0);
    do_cmd(OP_RESUME, 5'd0, 64'd0, 64'd0, 0, 0);
    do_cmd(OP_RD_REG, 5'd7, 64'd0, 64'h55, 0, 10);
    do_cmd(OP_HALT,   5'd0, 64'd0, 64'd0, 31, 0);
    do_cmd(OP_HALT,   5'd0, 64'd0, 64'd0, 0, 3);
    do_cmd(3'd7,      5'd0, 64'd0, 64'd0, 0, 0);
    do_cmd(OP_STEP,   5'd0, 64'd0, 64'd0, 3, 0);
    do_cmd(OP_RESUME, 5'd0, 64'd0, 64'd0, 0, 0);
    do_cmd(OP_STEP,   5'd0, 64'd0, 64'd0, 0, 0);

    // Reset in the middle of a drain drops the command and returns to RUN at once.
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_op_i = OP_HALT; pipe_busy_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("drain_hv", halt_valid_o, 1'b1);
    rstn_i = 1'b0;
    #1;
    check("mid_reset_ctl", {cmd_ready_o, rsp_valid_o, rsp_err_o, halted_o, halt_valid_o}, 5'b10000);
    @(negedge clk_i);
    rstn_i = 1'b1; pipe_busy_i = 1'b0;
    model_halted = 1'b0;
    do_cmd(OP_HALT, 5'd0, 64'd0, 64'd0, 2, 0);

    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      if (!model_halted && $urandom_range(0, 2) == 0) op = OP_HALT;
      busy_n = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 36) : $urandom_range(0, 6);
      do_cmd(op, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             busy_n, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
